// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - NREG x XLEN register file with bypass and pending-write scoreboard
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            ISS_V,
    input  logic [AW-1:0]   ISS_RD,
    input  logic            FLUSH,
    output logic [NREG-1:0] PEND
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            pend <= '0;
        end else begin
            if (WE3 && (A3 != '0)) begin
                regs[A3] <= WD3;
            end
            pend[0] <= 1'b0;
            // A same-cycle issue beats the write: the newer producer owns the register.
            for (int r = 1; r < NREG; r++) begin
                if (FLUSH) begin
                    pend[r] <= 1'b0;
                end else if (ISS_V && (ISS_RD == AW'(r))) begin
                    pend[r] <= 1'b1;
                end else if (WE3 && (A3 == AW'(r))) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if ((BYPASS != 0) && WE3 && (A3 == addr)) begin
            return WD3;
        end else begin
            return regs[addr];
        end
    endfunction

    // Writeback this cycle hides the pending bit unless the same register is re-issued.
    function automatic logic busy_port(input logic [AW-1:0] addr);
        logic hidden;
        hidden = (BYPASS != 0) && WE3 && (A3 == addr) && !(ISS_V && (ISS_RD == addr));
        return pend[addr] && !hidden;
    endfunction

    always_comb begin
        RD1   = '0;
        RD2   = '0;
        BUSY1 = 1'b0;
        BUSY2 = 1'b0;
        PEND  = '0;
        if (rst) begin
            RD1   = read_port(A1);
            RD2   = read_port(A2);
            BUSY1 = busy_port(A1);
            BUSY2 = busy_port(A2);
            PEND  = pend;
        end
    end

endmodule
